// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and bit-timing constants
package uart_pkg;

  localparam int DATA_W                 = 8;
  localparam int DEFAULT_CLOCKS_PER_BIT = 55;
  localparam int MIN_CNT_W              = 16;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_DATA       = 3'd2,
    ST_STOP       = 3'd3,
    ST_BREAK_WAIT = 3'd4
  } uart_state_t;

  // Mid-bit offset used to qualify the start bit.
  function automatic int half_bit(input int clocks_per_bit);
    return (clocks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the idle-high serial line
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Both flops reset to the line's idle level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver; UART_RX_FRAME_CHECK_EN adds stop-bit checking and break wait
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_done,
  output logic              rx_busy,
  output logic              frame_err
);

  localparam int CNT_W = ($clog2(CLOCKS_PER_BIT) > MIN_CNT_W) ? $clog2(CLOCKS_PER_BIT) : MIN_CNT_W;
  localparam logic [CNT_W-1:0] HALF = CNT_W'(half_bit(CLOCKS_PER_BIT));
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLOCKS_PER_BIT - 1);

  logic              rx_s;
  uart_state_t       state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [2:0]        idx, idx_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [DATA_W-1:0] data_n;
  logic              done_n;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

`ifdef UART_RX_FRAME_CHECK_EN
  logic ferr_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_err <= 1'b0;
    else     frame_err <= ferr_n;
  end
`else
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      rx_data <= '0;
      rx_done <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shreg   <= shreg_n;
      rx_data <= data_n;
      rx_done <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = rx_data;
    done_n  = 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
    ferr_n  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (!rx_s) state_n = ST_START;
      end
      ST_START: begin
        // A line that is high again at mid-bit was noise, not a start bit.
        if (cnt == HALF) begin
          cnt_n   = '0;
          state_n = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt == LAST) begin
          cnt_n        = '0;
          shreg_n[idx] = rx_s;
          if (idx == 3'd7) state_n = ST_STOP;
          else             idx_n   = idx + 3'd1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt == LAST) begin
          cnt_n  = '0;
          data_n = shreg;
          done_n = 1'b1;
`ifdef UART_RX_FRAME_CHECK_EN
          if (rx_s) begin
            state_n = ST_IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = ST_BREAK_WAIT;
          end
`else
          state_n = ST_IDLE;
`endif
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
`ifdef UART_RX_FRAME_CHECK_EN
      // Hold off until the line recovers so a break is not re-read as frames.
      ST_BREAK_WAIT: begin
        cnt_n = '0;
        if (rx_s) state_n = ST_IDLE;
      end
`endif
      default: state_n = ST_IDLE;
    endcase
  end

  assign rx_busy = (state != ST_IDLE);

endmodule
